// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO, models op latency, stalls D.
// Optional build macro MDU_MADD_EN enables madd/maddu/msub/msubu accumulation (ops 9-12).
module mdu_sequencer #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_valid,
    input  logic [3:0]  e_mduop,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] mdu_out
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;

    logic               is_mul_c;
    logic               is_div_c;
    logic               is_acc_c;
    logic               start_cls_c;
    logic [CNT_W-1:0]   cnt_load_c;

    logic signed [63:0] a_sx_c, b_sx_c;
    logic signed [31:0] a_s_c, b_s_c;
    logic [63:0]        prod_s_c, prod_u_c, hilo_c, res_c;
    logic [31:0]        quo_s_c, rem_s_c;

    // Op-class decode; accumulate ops fall back to "no op" when the feature is off
    always_comb begin
        is_mul_c = (e_mduop == OP_MULT) || (e_mduop == OP_MULTU);
        is_div_c = (e_mduop == OP_DIV)  || (e_mduop == OP_DIVU);
`ifdef MDU_MADD_EN
        is_acc_c = (e_mduop == OP_MADD) || (e_mduop == OP_MADDU) ||
                   (e_mduop == OP_MSUB) || (e_mduop == OP_MSUBU);
`else
        is_acc_c = 1'b0;
`endif
        start_cls_c = is_mul_c | is_div_c | is_acc_c;
        cnt_load_c  = is_div_c ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
    end

    // Result captured at start; divide-by-zero preserves the committed HI/LO
    always_comb begin
        a_sx_c   = {{32{e_a[31]}}, e_a};
        b_sx_c   = {{32{e_b[31]}}, e_b};
        a_s_c    = e_a;
        b_s_c    = e_b;
        prod_s_c = a_sx_c * b_sx_c;
        prod_u_c = {32'd0, e_a} * {32'd0, e_b};
        quo_s_c  = a_s_c / b_s_c;
        rem_s_c  = a_s_c % b_s_c;
        hilo_c   = {hi_q, lo_q};
        res_c    = hilo_c;
        case (e_mduop)
            OP_MULT:  res_c = prod_s_c;
            OP_MULTU: res_c = prod_u_c;
            OP_DIV:   if (e_b != 32'd0) res_c = {rem_s_c, quo_s_c};
            OP_DIVU:  if (e_b != 32'd0) res_c = {e_a % e_b, e_a / e_b};
            OP_MADD:  res_c = hilo_c + prod_s_c;
            OP_MADDU: res_c = hilo_c + prod_u_c;
            OP_MSUB:  res_c = hilo_c - prod_s_c;
            OP_MSUBU: res_c = hilo_c - prod_u_c;
            default:  res_c = hilo_c;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign start    = e_valid & start_cls_c & (state_q == S_IDLE);
    assign stall_md = d_is_md & (start | busy);

    always_comb begin
        mdu_out = 32'd0;
        if (e_mduop == OP_MFHI) begin
            mdu_out = hi_q;
        end else if (e_mduop == OP_MFLO) begin
            mdu_out = lo_q;
        end
    end

    // Next-state: start/move-to in IDLE, count down and commit in RUN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_hi_d = res_c[63:32];
                    pend_lo_d = res_c[31:0];
                    cnt_d     = cnt_load_c;
                    state_d   = S_RUN;
                end else if (e_valid && (e_mduop == OP_MTHI)) begin
                    hi_d = e_a;
                end else if (e_valid && (e_mduop == OP_MTLO)) begin
                    lo_d = e_a;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

endmodule
